// File: rtl/spi_flash_pkg.sv
// Shared constants for the SPI flash read sequencer: SPI master register map,
// status bit positions, control/opcode values, FSM state encoding and the
// header byte selector used when writing the tx register.
package spi_flash_pkg;

  // SPI master register addresses
  localparam logic [2:0] RXDATA  = 3'd0;
  localparam logic [2:0] TXDATA  = 3'd1;
  localparam logic [2:0] STATUS  = 3'd2;
  localparam logic [2:0] CONTROL = 3'd3;
  localparam logic [2:0] SSEL    = 3'd5;

  // Status register bit indices
  localparam int ST_RRDY = 7;
  localparam int ST_TMT  = 5;
  localparam int ST_TOE  = 4;
  localparam int ST_ROE  = 3;

  localparam logic [15:0] CTRL_SSO = 16'h0400;
  localparam logic [7:0]  OPC_READ = 8'h03;

  typedef enum logic [3:0] {
    S_IDLE, S_SEL, S_SSO_ON, S_TX_WR, S_POLL_RX,
    S_RX_RD, S_OUT, S_POLL_TMT, S_SSO_OFF, S_DONE
  } state_t;

  // Tx byte by position: 0 opcode, 1..3 address MSB first, 4+ dummy 0x00.
  function automatic logic [7:0] tx_byte(input logic [2:0] idx, input logic [23:0] addr);
    case (idx)
      3'd0:    return OPC_READ;
      3'd1:    return addr[23:16];
      3'd2:    return addr[15:8];
      3'd3:    return addr[7:0];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_bus_access.sv
// 3-cycle register access frame toward the SPI master.
// Ports: i_start/i_wr/i_addr/i_wdata launch a frame (accepted when idle or in
// the gap cycle), o_ack pulses in the gap cycle, o_rdata holds read data.
// Bus side: o_spi_select, o_mem_addr, o_data_from_cpu, o_read_n, o_write_n,
// i_data_to_cpu.
module spi_flash_bus_access
  import spi_flash_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_wr,
  input  logic [2:0]  i_addr,
  input  logic [15:0] i_wdata,
  output logic        o_ack,
  output logic [15:0] o_rdata,
  output logic        o_spi_select,
  output logic [2:0]  o_mem_addr,
  output logic [15:0] o_data_from_cpu,
  output logic        o_read_n,
  output logic        o_write_n,
  input  logic [15:0] i_data_to_cpu
);

  // phase 0 idle, 1/2 active, 3 idle gap
  logic [1:0]  r_phase;
  logic        r_wr;
  logic [2:0]  r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        w_active;
  logic        w_load;

  assign w_active = (r_phase == 2'd1) || (r_phase == 2'd2);
  // Loading in the gap cycle lets frames run back to back every 3 cycles.
  assign w_load   = i_start && ((r_phase == 2'd0) || (r_phase == 2'd3));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= 2'd0;
      r_wr    <= 1'b0;
      r_addr  <= 3'd0;
      r_wdata <= 16'h0000;
      r_rdata <= 16'h0000;
    end else if (w_load) begin
      r_phase <= 2'd1;
      r_wr    <= i_wr;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
    end else begin
      case (r_phase)
        2'd1: r_phase <= 2'd2;
        2'd2: begin
          r_phase <= 2'd3;
          if (!r_wr) r_rdata <= i_data_to_cpu;
        end
        default: r_phase <= 2'd0;
      endcase
    end
  end

  assign o_ack           = (r_phase == 2'd3);
  assign o_rdata         = r_rdata;
  assign o_spi_select    = w_active;
  assign o_mem_addr      = r_addr;
  assign o_data_from_cpu = r_wdata;
  assign o_read_n        = !(w_active && !r_wr);
  assign o_write_n       = !(w_active && r_wr);

endmodule

// File: rtl/spi_flash_read_sequencer.sv
// Sequences SPI master register accesses to perform a flash READ (0x03):
// slave select, SSO on, opcode + 3 address bytes, len+1 dummy bytes with
// data capture, wait for TMT, SSO off.
// Ports: req_valid/req_addr/req_len request in; busy/done/err status;
// out_data/out_valid/out_ready byte stream; spi_select/mem_addr/
// data_from_cpu/read_n/write_n/data_to_cpu SPI master register port.
module spi_flash_read_sequencer
  import spi_flash_pkg::*;
#(
  parameter int          LEN_W   = 8,
  parameter logic [15:0] SS_MASK = 16'h0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [23:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             spi_select,
  output logic [2:0]       mem_addr,
  output logic [15:0]      data_from_cpu,
  output logic             read_n,
  output logic             write_n,
  input  logic [15:0]      data_to_cpu
);

  localparam logic [LEN_W:0] REM_ONE = (LEN_W+1)'(1);

  state_t         r_state, w_state_n;
  logic [23:0]    r_addr;
  logic [LEN_W:0] r_rem;
  logic [1:0]     r_hdr;
  logic           r_in_hdr;
  logic           r_err;
  logic [7:0]     r_out_data;

  logic           w_start, w_wr, w_ack, w_repoll;
  logic [2:0]     w_addr, w_tx_idx;
  logic [15:0]    w_wdata, w_rdata;
  logic           w_unused;

  assign w_unused = &{1'b0, w_rdata[15:8]};

  always_comb begin
    w_state_n = r_state;
    w_tx_idx  = 3'd4;
    case (r_state)
      S_IDLE:     if (req_valid) w_state_n = S_SEL;
      S_SEL:      if (w_ack) w_state_n = S_SSO_ON;
      S_SSO_ON:   if (w_ack) begin w_state_n = S_TX_WR; w_tx_idx = 3'd0; end
      S_TX_WR:    if (w_ack) w_state_n = S_POLL_RX;
      S_POLL_RX:  if (w_ack && w_rdata[ST_RRDY]) w_state_n = S_RX_RD;
      S_RX_RD:    if (w_ack) begin
                    if (r_in_hdr) begin
                      w_state_n = S_TX_WR;
                      w_tx_idx  = {1'b0, r_hdr} + 3'd1;
                    end else begin
                      w_state_n = S_OUT;
                    end
                  end
      S_OUT:      if (out_ready) w_state_n = (r_rem == REM_ONE) ? S_POLL_TMT : S_TX_WR;
      S_POLL_TMT: if (w_ack && w_rdata[ST_TMT]) w_state_n = S_SSO_OFF;
      S_SSO_OFF:  if (w_ack) w_state_n = S_DONE;
      default:    w_state_n = S_IDLE;
    endcase

    // A frame is launched on entry to an access state, or again when a
    // status poll finishes without its condition met.
    w_repoll = w_ack && (w_state_n == r_state) &&
               ((r_state == S_POLL_RX) || (r_state == S_POLL_TMT));
    w_start  = (w_state_n != r_state) || w_repoll;
    w_wr     = 1'b0;
    w_addr   = RXDATA;
    w_wdata  = 16'h0000;
    case (w_state_n)
      S_SEL:      begin w_wr = 1'b1; w_addr = SSEL;    w_wdata = SS_MASK;  end
      S_SSO_ON:   begin w_wr = 1'b1; w_addr = CONTROL; w_wdata = CTRL_SSO; end
      S_TX_WR:    begin w_wr = 1'b1; w_addr = TXDATA;
                        w_wdata = {8'h00, tx_byte(w_tx_idx, r_addr)}; end
      S_POLL_RX,
      S_POLL_TMT: w_addr = STATUS;
      S_RX_RD:    w_addr = RXDATA;
      S_SSO_OFF:  begin w_wr = 1'b1; w_addr = CONTROL; w_wdata = 16'h0000; end
      default:    w_start = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= 24'h0;
      r_rem      <= '0;
      r_hdr      <= 2'd0;
      r_in_hdr   <= 1'b0;
      r_err      <= 1'b0;
      r_out_data <= 8'h00;
    end else begin
      r_state <= w_state_n;
      if (r_state == S_IDLE && req_valid) begin
        r_addr   <= req_addr;
        r_rem    <= {1'b0, req_len} + REM_ONE;
        r_hdr    <= 2'd0;
        r_in_hdr <= 1'b1;
        r_err    <= 1'b0;
      end
      if (w_ack && (r_state == S_POLL_RX || r_state == S_POLL_TMT))
        r_err <= r_err | w_rdata[ST_ROE] | w_rdata[ST_TOE];
      if (r_state == S_RX_RD && w_ack) begin
        if (r_in_hdr) begin
          r_hdr <= r_hdr + 2'd1;
          if (r_hdr == 2'd3) r_in_hdr <= 1'b0;
        end else begin
          r_out_data <= w_rdata[7:0];
        end
      end
      if (r_state == S_OUT && out_ready) r_rem <= r_rem - REM_ONE;
    end
  end

  assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done      = (r_state == S_DONE);
  assign err       = r_err;
  assign out_valid = (r_state == S_OUT);
  assign out_data  = r_out_data;

  spi_flash_bus_access u_bus (
    .clk             (clk),
    .reset           (reset),
    .i_start         (w_start),
    .i_wr            (w_wr),
    .i_addr          (w_addr),
    .i_wdata         (w_wdata),
    .o_ack           (w_ack),
    .o_rdata         (w_rdata),
    .o_spi_select    (spi_select),
    .o_mem_addr      (mem_addr),
    .o_data_from_cpu (data_from_cpu),
    .o_read_n        (read_n),
    .o_write_n       (write_n),
    .i_data_to_cpu   (data_to_cpu)
  );

endmodule

// File: tb/tb_spi_flash_read_sequencer.sv
// Bench for spi_flash_read_sequencer: SPI master + flash behavioural model,
// frame protocol checker and byte/tx-sequence scoreboard.
module tb_spi_flash_read_sequencer;
  localparam int          LEN_W   = 8;
  localparam logic [15:0] SS_MASK = 16'h0001;

  logic clk = 1'b0, reset = 1'b1, req_valid = 1'b0, out_ready = 1'b1;
  logic [23:0] req_addr = 24'h0;
  logic [LEN_W-1:0] req_len = '0;
  logic busy, done, err, out_valid, spi_select, read_n, write_n;
  logic [7:0] out_data;
  logic [2:0] mem_addr;
  logic [15:0] data_from_cpu, data_to_cpu = 16'h0;

  always #5 clk = ~clk;

  spi_flash_read_sequencer #(.LEN_W(LEN_W), .SS_MASK(SS_MASK)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_len(req_len), .busy(busy), .done(done), .err(err),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .spi_select(spi_select), .mem_addr(mem_addr), .data_from_cpu(data_from_cpu),
    .read_n(read_n), .write_n(write_n), .data_to_cpu(data_to_cpu)
  );

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flash content as a function of byte address.
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    return (a[7:0] + a[15:8] + 8'h3D) ^ (a[23:16] - 8'h01);
  endfunction

  // master/flash model state
  logic [15:0] m_ctrl, m_sso;
  logic        m_rrdy;
  logic [7:0]  m_rx;
  int          m_dly, m_k;
  logic [23:0] m_fa;
  bit          roe_inj = 0;
  logic [7:0]  tx_log[$];
  // protocol tracker
  bit          prev_sel, fr_bad, prev_ov, prev_or;
  int          fr_cnt;
  logic [2:0]  fr_addr;
  logic [15:0] fr_data;
  logic        fr_rd, fr_wr;
  logic [7:0]  prev_od;
  // scoreboard
  logic [7:0]  exp_q[$], exp_tx[$], out_log[$];
  bit          exp_err;
  int          mism, done_cnt = 0, rdy_mode = 0;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      m_ctrl = 0; m_sso = 0; m_rrdy = 0; m_rx = 0; m_dly = -1; m_k = 0; m_fa = 0;
      prev_sel = 0; prev_ov = 0; prev_or = 0; fr_cnt = 0; data_to_cpu = 16'h0;
    end else begin
      if (m_dly == 0) begin m_rrdy = 1; m_dly = -1; end
      else if (m_dly > 0) m_dly--;
      if (spi_select) begin
        if (!prev_sel) begin
          fr_cnt = 1; fr_addr = mem_addr; fr_data = data_from_cpu;
          fr_rd = read_n; fr_wr = write_n; fr_bad = !(read_n ^ write_n);
          if (!write_n) begin
            case (mem_addr)
              3'd1: begin
                tx_log.push_back(data_from_cpu[7:0]);
                chk("sso_during_tx", {m_sso, m_ctrl}, {SS_MASK, 16'h0400});
                if (m_k == 1) m_fa[23:16] = data_from_cpu[7:0];
                if (m_k == 2) m_fa[15:8]  = data_from_cpu[7:0];
                if (m_k == 3) m_fa[7:0]   = data_from_cpu[7:0];
                m_rx = (m_k < 4) ? 8'hC3 : flash_byte(m_fa + 24'(m_k - 4));
                m_k++; m_rrdy = 0; m_dly = $urandom_range(0, 5);
              end
              3'd3: begin m_ctrl = data_from_cpu; if (data_from_cpu == 16'h0400) m_k = 0; end
              3'd5: m_sso = data_from_cpu;
              default: ;
            endcase
          end else begin
            case (mem_addr)
              3'd0: begin data_to_cpu = {8'h00, m_rx}; m_rrdy = 0; end
              3'd2: data_to_cpu = {8'h00, m_rrdy, 1'b0, (m_dly < 0), 1'b0, roe_inj, 3'b000};
              default: data_to_cpu = 16'h0;
            endcase
          end
        end else begin
          fr_cnt++;
          if (mem_addr !== fr_addr || data_from_cpu !== fr_data ||
              read_n !== fr_rd || write_n !== fr_wr) fr_bad = 1;
        end
      end else if (prev_sel) begin
        chk("frame_len", fr_cnt, 2);
        chk("frame_stable", fr_bad, 0);
        chk("gap_strobes", {read_n, write_n}, 2'b11);
      end
      prev_sel = spi_select;

      if (prev_ov && !prev_or) begin
        chk("out_hold_valid", out_valid, 1);
        chk("out_hold_data", out_data, prev_od);
      end
      if (out_valid && out_ready) begin
        out_log.push_back(out_data);
        if (exp_q.size() == 0) chk("out_unexpected", out_data, 64'hFFFF);
        else chk("out_byte", out_data, exp_q.pop_front());
      end
      prev_ov = out_valid; prev_or = out_ready; prev_od = out_data;

      if (done) begin
        done_cnt++;
        chk("done_err", err, exp_err);
        chk("done_busy", busy, 0);
        chk("done_remaining", exp_q.size(), 0);
        mism = 0;
        if (tx_log.size() != exp_tx.size()) mism = 999;
        else foreach (exp_tx[i]) if (tx_log[i] !== exp_tx[i]) mism++;
        chk("done_tx_seq", mism, 0);
        chk("done_sso_off", m_ctrl, 16'h0000);
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  task automatic issue_req(input logic [23:0] a, input int len, input bit inj, input int mode);
    @(posedge clk); #1;
    exp_q.delete(); exp_tx.delete(); tx_log.delete(); out_log.delete();
    for (int i = 0; i <= len; i++) exp_q.push_back(flash_byte(a + 24'(i)));
    exp_tx.push_back(8'h03); exp_tx.push_back(a[23:16]);
    exp_tx.push_back(a[15:8]); exp_tx.push_back(a[7:0]);
    for (int i = 0; i <= len; i++) exp_tx.push_back(8'h00);
    exp_err = inj; roe_inj = inj; rdy_mode = mode;
    req_valid = 1; req_addr = a; req_len = len[LEN_W-1:0];
    @(posedge clk); #1;
    chk("accept_busy", busy, 1);
    chk("accept_err_clr", err, 0);
    chk("first_strobe", {spi_select, write_n, read_n, mem_addr, data_from_cpu},
        {1'b1, 1'b0, 1'b1, 3'd5, SS_MASK});
    // request while busy must be ignored
    req_addr = 24'($urandom); req_len = LEN_W'($urandom);
    repeat (3) @(posedge clk);
    #1 req_valid = 0;
  endtask

  task automatic wait_done();
    int c = 0;
    bit got = 0;
    while (!got && c < 5000) begin
      @(negedge clk); c++;
      if (done) got = 1;
    end
    chk("done_seen", got, 1);
    @(posedge clk); #1;
    roe_inj = 0; rdy_mode = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_outs"}, {busy, done, err, out_valid, spi_select, read_n, write_n},
        7'b0000011);
    chk({tag, "_data"}, {out_data, mem_addr, data_from_cpu}, 27'h0);
  endtask

  initial begin
    int c, n;
    repeat (3) @(posedge clk);
    #1 check_reset_vals("reset");
    reset = 0;

    // single byte
    issue_req(24'h012345, 0, 0, 0);
    wait_done();
    chk("single_tx", {tx_log[0], tx_log[1], tx_log[2], tx_log[3], tx_log[4]}, 40'h0301234500);
    chk("single_out", {out_log.size(), out_log[0]}, {32'd1, 8'hA5});

    // burst
    issue_req(24'h0123B0, 3, 0, 0);
    wait_done();
    chk("burst_out", {out_log[0], out_log[1], out_log[2], out_log[3]}, 32'h10111213);

    // backpressure on byte 0
    issue_req(24'h00ABCD, 1, 0, 2);
    c = 0;
    while (!out_valid && c < 2000) begin @(negedge clk); c++; end
    chk("bp_valid_seen", out_valid, 1);
    n = tx_log.size();
    repeat (500) @(negedge clk);
    chk("bp_no_tx", tx_log.size(), n);
    chk("bp_tx_before", n, 5);
    chk("bp_still_valid", out_valid, 1);
    rdy_mode = 0;
    wait_done();
    chk("bp_out_cnt", out_log.size(), 2);

    // error, then cleared by next request
    issue_req(24'h3C0011, 1, 1, 0);
    wait_done();
    issue_req(24'h3C0011, 0, 0, 0);
    wait_done();

    // reset at 2nd tx byte
    issue_req(24'h55AA01, 3, 0, 1);
    c = 0;
    while (tx_log.size() < 2 && c < 2000) begin @(negedge clk); c++; end
    chk("rst_tx2_seen", tx_log.size(), 2);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1;
    check_reset_vals("midreset");
    exp_q.delete(); reset = 0; rdy_mode = 0;
    issue_req(24'h0F0F0F, 2, 0, 0);
    wait_done();

    // random traffic
    for (int t = 0; t < 15; t++) begin
      issue_req(24'($urandom), $urandom_range(0, 6), ($urandom_range(0, 3) == 0), 1);
      wait_done();
    end
    chk("done_count", done_cnt, 21);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_flash_read_sequencer.md
# spi_flash_read_sequencer

Hardware read sequencer that sits directly upstream of the SPI flash master and drives its 3-bit register port in place of the CPU. It turns one read request (24-bit flash address, byte count) into a standard READ (0x03) transaction: slave-select setup, opcode, address bytes, dummy bytes, and return-data capture. Returned bytes leave on a valid/ready byte stream. The SPI master keeps full ownership of SCLK, MOSI and SS_n timing; this block only sequences register accesses.

## Interface
Parameters:
- LEN_W, 8: width of the length field; a request transfers len+1 bytes (1..2^LEN_W).
- SS_MASK, 16'h0001: value written to the master slave-enable register.

Ports (single clock; reset is synchronous, active-high):
- clk  in  1  system clock, shared with the SPI master.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request strobe; accepted only when busy=0.
- req_addr  in  24  flash byte address.
- req_len  in  LEN_W  byte count minus one.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse at end of request.
- err  out  1  valid with done; set if status ever showed ROE (bit 3) or TOE (bit 4).
- out_data  out  8  returned flash byte.
- out_valid  out  1  byte available; held until out_ready.
- out_ready  in  1  downstream accept.
- spi_select  out  1  master chip select.
- mem_addr  out  3  master register address.
- data_from_cpu  out  16  master write data.
- read_n  out  1  master read strobe, active-low.
- write_n  out  1  master write strobe, active-low.
- data_to_cpu  in  16  master registered read data.

## Operation
- Bus access: a 3-cycle frame. Cycles 1–2 drive spi_select=1, mem_addr, data, and strobe low. Cycle 3 drives spi_select=0 with both strobes high (idle gap). Read data is captured from data_to_cpu at the clock edge ending cycle 2. Addresses and data are stable through all active cycles.
- Register addresses: 0 rxdata, 1 txdata, 2 status, 3 control, 5 slave-enable.
- Status bits: RRDY=7, TMT=5, TOE=4, ROE=3.
- FSM states and transitions:
  - IDLE: on req_valid, latch addr/len and clear err → SEL.
  - SEL: write addr5=SS_MASK → SSO_ON.
  - SSO_ON: write addr3=16'h0400 → TX_WR.
  - TX_WR: write addr1 with the next tx byte → POLL_RX.
  - POLL_RX: read addr2 repeatedly until RRDY=1 → RX_RD.
  - RX_RD: read addr0.
    - During the 4 header bytes, discard the result → TX_WR.
    - Otherwise → OUT.
  - OUT: out_valid=1, out_data=rx[7:0]. On out_ready, decrement the remaining count. If more bytes remain → TX_WR, else → POLL_TMT.
  - POLL_TMT: read addr2 until TMT=1 → SSO_OFF.
  - SSO_OFF: write addr3=16'h0000 → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Tx byte sequence: 0x03, addr[23:16], addr[15:8], addr[7:0], then len+1 bytes of 0x00.
- Byte counter: LEN_W+1 bits, no wrap. The header counter is 2 bits.
- err: OR of status bits 3 and 4 across every status read in the request. It is cleared only on acceptance of a new request.
- Backpressure: the next dummy byte is not written until the current byte is accepted. The flash sees SS_n held low with SCLK idle, which is legal.
- req_valid while busy is ignored, with no queueing.

## Timing
- Reset values: busy=0, done=0, err=0, out_valid=0, out_data=0, spi_select=0, read_n=1, write_n=1, mem_addr=0, data_from_cpu=0.
- Acceptance to the first write strobe (SEL cycle 1): 1 cycle.
- out_valid rises the cycle after the RX_RD frame ends.
- Transfer occurs on the out_valid & out_ready cycle. out_valid drops the next cycle, or, on the last byte, the FSM proceeds to POLL_TMT.
- done occurs 1 cycle after the SSO_OFF frame ends. busy falls in the same cycle as done.
- Reset asserted mid-transfer: all outputs return to their reset values at the next edge, including an aborted access frame. A system-wide reset also resets the master. A standalone reset leaves master SSO set until the next request's SSO_ON/SSO_OFF.

## Structure
- Package spi_flash_pkg:
  - register address constants (RXDATA, TXDATA, STATUS, CONTROL, SSEL);
  - status bit indices;
  - CTRL_SSO=16'h0400;
  - OPC_READ=8'h03;
  - FSM state enum.
- Sub-module spi_flash_bus_access: the 3-cycle frame engine.
  - Inputs: start, wr, addr, wdata.
  - Outputs: ack pulse, rdata.
  - The top module holds the FSM and counters only.

## Test plan
- Single byte: addr=0x012345, len=0, slave model returning 0xA5 on the 5th byte.
  - Master sees tx 0x03,0x01,0x23,0x45,0x00.
  - Exactly one out byte 0xA5; done=1 and err=0.
- Burst: len=3, model returns 0x10..0x13.
  - Four out bytes in order.
  - SS_n continuously low from the opcode through the last byte, then high after SSO_OFF.
- Backpressure: len=1, out_ready held low 500 cycles on byte 0.
  - No TX_WR for byte 1 until accept; data is not lost or duplicated.
- Error: force master ROE (status 0x0008) during a poll.
  - err=1 with done; the next request clears err.
- Protocol: check every access for 2 active cycles plus 1 idle cycle and stable mem_addr/data. A req_valid during busy must not alter the transfer.
- Reset at the 2nd tx byte: all outputs equal reset values after one edge. A following request completes correctly.
